dl_region_router: RTL

DL_REGION_ROUTER -- requirements
Module: dl_region_router

---
 rtl/dl_pkg.sv | 23 ++
 rtl/dl_reset_gen.sv | 49 ++++
 rtl/dl_region_router.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/dl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dl_pkg : shared types and constants for the download router      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package dl_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } dl_state_t;

  localparam int DL_NREG_DEFAULT = 4;
  localparam int DL_AW_DEFAULT   = 25;

  localparam logic [DL_NREG_DEFAULT*DL_AW_DEFAULT-1:0] DL_REG_BASE_DEFAULT =
    {25'h32000, 25'h14000, 25'h7000, 25'h0};

  localparam logic [7:0] DL_ROM_INDEX = 8'd0;
  localparam logic [7:0] DL_MOD_INDEX = 8'd1;

endpackage
`default_nettype wire

// File: rtl/dl_reset_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dl_reset_gen : ROM-loaded flag and core reset with delayed pulse |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module dl_reset_gen #(
  parameter logic [15:0] RST_HOLD = 16'hFFFF
) (
  input  logic clk_sys,
  input  logic RESET,
  input  logic ext_reset,
  input  logic ioctl_download,
  input  logic fsm_idle,
  output logic rom_loaded,
  output logic core_reset
);

  // Survive RESET so a soft reset does not invalidate an already loaded ROM.
  logic        r_dl_seen    = 1'b0;
  logic        r_rom_loaded = 1'b0;
  logic [15:0] r_cnt;
  logic        r_core_reset;
  logic        w_hold;

  always_ff @(posedge clk_sys) begin
    if (ioctl_download) begin
      r_dl_seen <= 1'b1;
    end
    if (!ioctl_download && r_dl_seen && fsm_idle) begin
      r_rom_loaded <= 1'b1;
    end
  end

  assign w_hold = RESET | ext_reset | ~r_rom_loaded;

  always_ff @(posedge clk_sys) begin
    if (w_hold) begin
      r_cnt <= RST_HOLD;
    end else if (r_cnt != 16'd0) begin
      r_cnt <= r_cnt - 16'd1;
    end
    r_core_reset <= w_hold | (r_cnt == 16'd1);
  end

  assign rom_loaded = r_rom_loaded;
  assign core_reset = r_core_reset;

endmodule
`default_nettype wire

// File: rtl/dl_region_router.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dl_region_router : splits ioctl ROM download into toggle-handshake|
// | regions, captures variant byte, sequences core reset. Rev 1.0    |
// +------------------------------------------------------------------+
module dl_region_router
  import dl_pkg::*;
#(
  parameter int                  NREG      = DL_NREG_DEFAULT,
  parameter int                  AW        = DL_AW_DEFAULT,
  parameter logic [NREG*AW-1:0]  REG_BASE  = DL_REG_BASE_DEFAULT,
  parameter logic [7:0]          ROM_INDEX = DL_ROM_INDEX,
  parameter logic [7:0]          MOD_INDEX = DL_MOD_INDEX,
  parameter logic [15:0]         RST_HOLD  = 16'hFFFF
) (
  input  logic            clk_sys,
  input  logic            RESET,
  input  logic            ext_reset,
  input  logic            ioctl_download,
  input  logic            ioctl_wr,
  input  logic [7:0]      ioctl_index,
  input  logic [AW-1:0]   ioctl_addr,
  input  logic [7:0]      ioctl_dout,
  output logic            ioctl_wait,
  output logic [NREG-1:0] reg_req,
  input  logic [NREG-1:0] reg_ack,
  output logic [NREG-1:0] reg_sel,
  output logic [AW-1:0]   reg_addr,
  output logic [7:0]      reg_data,
  output logic [7:0]      mod,
  output logic            rom_loaded,
  output logic            core_reset,
  output logic            overrun
);

  dl_state_t       r_state;
  dl_state_t       w_state_next;
  logic [NREG-1:0] r_req = '0;
  logic            r_rom_strobe_d = 1'b0;
  logic [NREG-1:0] r_sel;
  logic [AW-1:0]   r_addr;
  logic [7:0]      r_data;
  logic [7:0]      r_mod;
  logic            r_overrun;

  logic [NREG-1:0] w_sel;
  logic [AW-1:0]   w_base;
  logic            w_rom_strobe;
  logic            w_rom_edge;
  logic            w_mod_strobe;
  logic            w_ack_done;
  logic            w_accept;
  logic            w_drop;

  assign w_rom_strobe = ioctl_wr & ioctl_download & (ioctl_index == ROM_INDEX);
  assign w_rom_edge   = w_rom_strobe & ~r_rom_strobe_d;
  assign w_mod_strobe = ioctl_wr & (ioctl_index == MOD_INDEX);
  assign w_ack_done   = (((reg_ack ^ r_req) & r_sel) == '0);

  // Bases ascend, so the last base not above the address wins.
  always_comb begin
    w_sel    = '0;
    w_sel[0] = 1'b1;
    w_base   = REG_BASE[AW-1:0];
    for (int i = 1; i < NREG; i++) begin
      if (ioctl_addr >= REG_BASE[i*AW +: AW]) begin
        w_sel    = '0;
        w_sel[i] = 1'b1;
        w_base   = REG_BASE[i*AW +: AW];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rom_edge) begin
          w_accept     = 1'b1;
          w_state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        w_drop = w_rom_edge;
        if (w_ack_done) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_sys) begin
    r_rom_strobe_d <= w_rom_strobe;
    if (RESET) begin
      r_sel     <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_mod     <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sel  <= w_sel;
        r_addr <= ioctl_addr - w_base;
        r_data <= ioctl_dout;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
      if (w_mod_strobe) begin
        r_mod <= ioctl_dout;
      end
    end
  end

  // Toggle parity must match the far side across RESET, so no reset here.
  always_ff @(posedge clk_sys) begin
    if (!RESET && w_accept) begin
      r_req <= r_req ^ w_sel;
    end
  end

  dl_reset_gen #(
    .RST_HOLD (RST_HOLD)
  ) u_reset_gen (
    .clk_sys        (clk_sys),
    .RESET          (RESET),
    .ext_reset      (ext_reset),
    .ioctl_download (ioctl_download),
    .fsm_idle       (r_state == IDLE),
    .rom_loaded     (rom_loaded),
    .core_reset     (core_reset)
  );

  assign ioctl_wait = (r_state == WAIT_ACK);
  assign reg_req    = r_req;
  assign reg_sel    = r_sel;
  assign reg_addr   = r_addr;
  assign reg_data   = r_data;
  assign mod        = r_mod;
  assign overrun    = r_overrun;

endmodule
`default_nettype wire
